// File: rtl/sram_slot_arbiter_pkg.sv
// Shared types and constants for the SRAM time-slot arbiter.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    SETUP = 3'd2,
    GRANT = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int DEF_TIMEOUT = 32;
  localparam int REQ_DELAY   = 0;
  localparam int REQ_LOOP    = 1;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_slot_arbiter_if.sv
// Requester/SRAM bundle for the slot arbiter; the arbiter uses the slave modport.
interface sram_slot_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16
) ();
  logic                        i_frame_start;
  logic [NUM_REQ-1:0]          i_req;
  logic [NUM_REQ-1:0]          i_done;
  logic [NUM_REQ*ADDR_W-1:0]   i_addr;
  logic [NUM_REQ-1:0]          i_we_n;
  logic [NUM_REQ*DATA_W-1:0]   i_wdata;
  logic [DATA_W-1:0]           i_dq_in;
  logic                        i_clr_flags;
  logic [NUM_REQ-1:0]          o_grant;
  logic [DATA_W-1:0]           o_rdata;
  logic [ADDR_W-1:0]           o_sram_addr;
  logic                        o_sram_we_n;
  logic                        o_dq_oe;
  logic [DATA_W-1:0]           o_dq_out;
  logic                        o_busy;
  logic                        o_timeout;
  logic                        o_overrun;

  modport slave (
    input  i_frame_start, i_req, i_done, i_addr, i_we_n, i_wdata, i_dq_in, i_clr_flags,
    output o_grant, o_rdata, o_sram_addr, o_sram_we_n, o_dq_oe, o_dq_out,
           o_busy, o_timeout, o_overrun
  );

  modport master (
    output i_frame_start, i_req, i_done, i_addr, i_we_n, i_wdata, i_dq_in, i_clr_flags,
    input  o_grant, o_rdata, o_sram_addr, o_sram_we_n, o_dq_oe, o_dq_out,
           o_busy, o_timeout, o_overrun
  );
endinterface

// File: rtl/sram_slot_arbiter.sv
// Per-frame round of fixed-order SRAM slots with a one-cycle turnaround gap.
// Optional SRAM_ARB_ADDR_SETUP_EN inserts an address-setup cycle before each grant.
module sram_slot_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_slot_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                timeout_q, overrun_q;
  logic                timeout_set, overrun_set;

  // Per-requester mux legs: address follows the slot index (needed in SETUP
  // before any grant), write data/enable follow the registered grant only.
  logic [NUM_REQ-1:0]              sel_oh;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_m;
  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata_m;
  logic [NUM_REQ-1:0]              wen_m;

  genvar k;
  for (k = 0; k < NUM_REQ; k++) begin : g_mux
    assign sel_oh[k]  = (idx_q == IDX_W'(k));
    assign addr_m[k]  = sel_oh[k]  ? bus.i_addr[k*ADDR_W +: ADDR_W]  : '0;
    assign wdata_m[k] = grant_q[k] ? bus.i_wdata[k*DATA_W +: DATA_W] : '0;
    assign wen_m[k]   = grant_q[k] & ~bus.i_we_n[k];
  end

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      sel_addr  = sel_addr  | addr_m[j];
      sel_wdata = sel_wdata | wdata_m[j];
    end
  end

  logic req_sel, done_sel, wr_act, addr_live;
  assign req_sel  = |(sel_oh  & bus.i_req);
  assign done_sel = |(grant_q & bus.i_done);
  assign wr_act   = |wen_m;
`ifdef SRAM_ARB_ADDR_SETUP_EN
  assign addr_live = (|grant_q) | (state_q == SETUP);
`else
  assign addr_live = |grant_q;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_frame_start) begin
          idx_d   = '0;
          state_d = ARB;
        end
      end
      ARB: begin
        if (req_sel) begin
          cnt_d = '0;
`ifdef SRAM_ARB_ADDR_SETUP_EN
          state_d = SETUP;
`else
          state_d = GRANT;
          grant_d = sel_oh;
`endif
        end else if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SETUP: begin
        state_d = GRANT;
        grant_d = sel_oh;
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the limit cycle is a normal finish.
        if (done_sel) begin
          state_d = GAP;
        end else if (cnt_q == CNT_LIM) begin
          state_d     = GAP;
          timeout_set = 1'b1;
        end else begin
          grant_d = grant_q;
        end
      end
      GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ARB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun_set = bus.i_frame_start & (state_q != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      if (addr_live) addr_q <= sel_addr;
      if (timeout_set)          timeout_q <= 1'b1;
      else if (bus.i_clr_flags) timeout_q <= 1'b0;
      if (overrun_set)          overrun_q <= 1'b1;
      else if (bus.i_clr_flags) overrun_q <= 1'b0;
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_rdata     = bus.i_dq_in;
  assign bus.o_sram_addr = addr_live ? sel_addr : addr_q;
  assign bus.o_sram_we_n = ~wr_act;
  assign bus.o_dq_oe     = wr_act;
  assign bus.o_dq_out    = sel_wdata;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_timeout   = timeout_q;
  assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter; follows SRAM_ARB_ADDR_SETUP_EN if defined.
module tb_sram_slot_arbiter;
  import sram_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 32;

  logic clk, rst;
  int   n_chk, n_fail;

  sram_slot_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_slot_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each tick lands 2ns into the next cycle; checks run 1ns after driving.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_addr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    bus.i_addr = {a1, a0};
  endtask

  task automatic setup_cycle(input logic [ADDR_W-1:0] exp_addr);
`ifdef SRAM_ARB_ADDR_SETUP_EN
    tick(); #1;
    n_chk++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL setup_grant: got %b want 00", bus.o_grant); end
    n_chk++; if (bus.o_sram_we_n !== 1'b1 || bus.o_dq_oe !== 1'b0) begin n_fail++; $display("FAIL setup_we: got we_n=%b oe=%b want 1/0", bus.o_sram_we_n, bus.o_dq_oe); end
    n_chk++; if (bus.o_sram_addr !== exp_addr) begin n_fail++; $display("FAIL setup_addr: got %h want %h", bus.o_sram_addr, exp_addr); end
`else
    if (exp_addr === 'x) $display("unreachable");
`endif
  endtask

  task automatic strobe();
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_chk++; if (bus.o_grant !== 2'b00 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_grant_busy: got %b/%b want 00/0", bus.o_grant, bus.o_busy); end
    n_chk++; if (bus.o_sram_we_n !== 1'b1 || bus.o_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_we_oe: got %b/%b want 1/0", bus.o_sram_we_n, bus.o_dq_oe); end
    n_chk++; if (bus.o_sram_addr !== 20'h0 || bus.o_dq_out !== 16'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.o_sram_addr, bus.o_dq_out); end
    n_chk++; if (bus.o_timeout !== 1'b0 || bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b/%b want 0/0", bus.o_timeout, bus.o_overrun); end
    bus.i_dq_in = 16'h5A3C; #1;
    n_chk++; if (bus.o_rdata !== 16'h5A3C) begin n_fail++; $display("FAIL rdata_pass: got %h want 5a3c", bus.o_rdata); end
    tick(); tick();
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_both();
    bus.i_req = 2'b11; bus.i_we_n = 2'b11;
    set_addr(20'h00AAA, 20'h00BBB);
    strobe(); #1;                                     // t+1: ARB idx0
    n_chk++; if (bus.o_busy !== 1'b1 || bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL both_arb: got busy=%b grant=%b want 1/00", bus.o_busy, bus.o_grant); end
    setup_cycle(20'h00AAA);
    for (int c = 0; c < 3; c++) begin                 // t+2..t+4
      tick();
      if (c == 2) bus.i_done = 2'b01;
      #1;
      n_chk++; if (bus.o_grant !== 2'b01) begin n_fail++; $display("FAIL both_grant0 c%0d: got %b want 01", c, bus.o_grant); end
    end
    n_chk++; if (bus.o_sram_addr !== 20'h00AAA) begin n_fail++; $display("FAIL both_addr0: got %h want 00aaa", bus.o_sram_addr); end
    tick(); bus.i_done = 2'b00; #1;                   // t+5: GAP
    n_chk++; if (bus.o_grant !== 2'b00 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL both_gap: got grant=%b busy=%b want 00/1", bus.o_grant, bus.o_busy); end
    tick(); #1;                                       // t+6: ARB idx1
    n_chk++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL both_arb1: got %b want 00", bus.o_grant); end
    setup_cycle(20'h00BBB);
    tick(); #1;                                       // t+7
    n_chk++; if (bus.o_grant !== 2'b10 || bus.o_sram_addr !== 20'h00BBB) begin n_fail++; $display("FAIL both_grant1: got %b/%h want 10/00bbb", bus.o_grant, bus.o_sram_addr); end
    tick(); bus.i_done = 2'b10; #1;                   // t+8
    n_chk++; if (bus.o_grant !== 2'b10) begin n_fail++; $display("FAIL both_grant1b: got %b want 10", bus.o_grant); end
    tick(); bus.i_done = 2'b00; #1;                   // t+9: GAP
    n_chk++; if (bus.o_grant !== 2'b00 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL both_gap1: got %b/%b want 00/1", bus.o_grant, bus.o_busy); end
    tick(); #1;                                       // t+10: IDLE
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL both_idle: got busy=%b want 0", bus.o_busy); end
  endtask

  task automatic test_skip();
    bus.i_req = 2'b10;
    strobe(); #1;                                     // t+1: ARB idx0
    tick(); #1;                                       // t+2: ARB idx1
    n_chk++; if (bus.o_grant !== 2'b00 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL skip_arb1: got %b/%b want 00/1", bus.o_grant, bus.o_busy); end
    setup_cycle(20'h00BBB);
    tick(); bus.i_done = 2'b11; #1;                   // t+3; done[0] must be ignored
    n_chk++; if (bus.o_grant !== 2'b10) begin n_fail++; $display("FAIL skip_grant: got %b want 10", bus.o_grant); end
    tick(); bus.i_done = 2'b00; tick(); #1;
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL skip_end: got busy=%b want 0", bus.o_busy); end
    bus.i_req = 2'b00;
    strobe(); tick(); #1;                             // t+2: ARB idx1
    n_chk++; if (bus.o_busy !== 1'b1 || bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL noreq_t2: got %b/%b want 1/00", bus.o_busy, bus.o_grant); end
    tick(); #1;                                       // t+3: IDLE
    n_chk++; if (bus.o_busy !== 1'b0 || bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL noreq_t3: got %b/%b want 0/00", bus.o_busy, bus.o_grant); end
  endtask

  task automatic test_write();
    bus.i_req = 2'b01; bus.i_we_n = 2'b10;
    set_addr(20'h00123, 20'h00777);
    bus.i_wdata = {16'h1111, 16'hBEEF};
    strobe();
    setup_cycle(20'h00123);
    tick(); #1;
    n_chk++; if (bus.o_sram_addr !== 20'h00123 || bus.o_dq_out !== 16'hBEEF) begin n_fail++; $display("FAIL wr_bus: got %h/%h want 00123/beef", bus.o_sram_addr, bus.o_dq_out); end
    n_chk++; if (bus.o_dq_oe !== 1'b1 || bus.o_sram_we_n !== 1'b0) begin n_fail++; $display("FAIL wr_ctl: got oe=%b we_n=%b want 1/0", bus.o_dq_oe, bus.o_sram_we_n); end
    bus.i_done = 2'b01;
    tick(); bus.i_done = 2'b00; set_addr(20'h00FFF, 20'h00777); #1;   // GAP
    n_chk++; if (bus.o_dq_oe !== 1'b0 || bus.o_sram_we_n !== 1'b1) begin n_fail++; $display("FAIL gap_ctl: got oe=%b we_n=%b want 0/1", bus.o_dq_oe, bus.o_sram_we_n); end
    n_chk++; if (bus.o_sram_addr !== 20'h00123) begin n_fail++; $display("FAIL gap_addr_hold: got %h want 00123", bus.o_sram_addr); end
    tick(); tick(); #1;
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL wr_end: got busy=%b want 0", bus.o_busy); end
    bus.i_we_n = 2'b11;
  endtask

  task automatic test_timeout();
    int held;
    bus.i_req = 2'b01; bus.i_done = 2'b00;
    strobe();
    setup_cycle(20'h00FFF);
    held = 0;
    for (int c = 0; c < TIMEOUT + 2; c++) begin
      tick(); #1;
      if (bus.o_grant == 2'b01) held++;
    end
    n_chk++; if (held !== TIMEOUT) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", held, TIMEOUT); end
    n_chk++; if (bus.o_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b want 1", bus.o_timeout); end
    tick();
    bus.i_clr_flags = 1'b1; tick(); bus.i_clr_flags = 1'b0; #1;
    n_chk++; if (bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_clr: got %b/%b want 0/0", bus.o_timeout, bus.o_busy); end
    // done on the limit cycle is a normal finish
    strobe();
    setup_cycle(20'h00FFF);
    for (int c = 0; c < TIMEOUT; c++) begin
      tick();
      if (c == TIMEOUT - 1) bus.i_done = 2'b01;
      #1;
    end
    tick(); bus.i_done = 2'b00; #1;
    n_chk++; if (bus.o_grant !== 2'b00 || bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL done_at_limit: got grant=%b to=%b want 00/0", bus.o_grant, bus.o_timeout); end
    tick(); tick();
  endtask

  task automatic test_overrun_reset();
    bus.i_req = 2'b01; bus.i_we_n = 2'b10;
    set_addr(20'h00456, 20'h00777);
    strobe();
    setup_cycle(20'h00456);
    tick();
    strobe(); #1;                                     // strobe while granted
    n_chk++; if (bus.o_overrun !== 1'b1 || bus.o_grant !== 2'b01) begin n_fail++; $display("FAIL overrun: got ov=%b grant=%b want 1/01", bus.o_overrun, bus.o_grant); end
    bus.i_done = 2'b01; tick(); bus.i_done = 2'b00;
    bus.i_clr_flags = 1'b1; bus.i_frame_start = 1'b1;  // set beats clear
    tick(); bus.i_frame_start = 1'b0; bus.i_clr_flags = 1'b0; #1;
    n_chk++; if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b want 1", bus.o_overrun); end
    tick(); #1;
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL overrun_no_restart: got busy=%b want 0", bus.o_busy); end
    bus.i_clr_flags = 1'b1; tick(); bus.i_clr_flags = 1'b0; #1;
    n_chk++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr: got %b want 0", bus.o_overrun); end
    strobe();
    setup_cycle(20'h00456);
    tick(); #1;
    n_chk++; if (bus.o_dq_oe !== 1'b1) begin n_fail++; $display("FAIL pre_rst_write: got oe=%b want 1", bus.o_dq_oe); end
    #2 rst = 1'b1; #1;                                // mid-cycle, no clock edge
    n_chk++; if (bus.o_sram_we_n !== 1'b1 || bus.o_dq_oe !== 1'b0 || bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL async_rst: got we_n=%b oe=%b grant=%b want 1/0/00", bus.o_sram_we_n, bus.o_dq_oe, bus.o_grant); end
    n_chk++; if (bus.o_busy !== 1'b0 || bus.o_sram_addr !== 20'h0) begin n_fail++; $display("FAIL async_rst_state: got busy=%b addr=%h want 0/0", bus.o_busy, bus.o_sram_addr); end
    tick(); #2 rst = 1'b0;
    bus.i_we_n = 2'b11;
    tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    bus.i_frame_start = 1'b0; bus.i_req = '0; bus.i_done = '0;
    bus.i_addr = '0; bus.i_we_n = '1; bus.i_wdata = '0;
    bus.i_dq_in = '0; bus.i_clr_flags = 1'b0;
    test_reset();
    test_both();
    test_skip();
    test_write();
    test_timeout();
    test_overrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_slot_arbiter.md
Name: sram_slot_arbiter

Overview:
- Time-slot arbiter that shares the single external SRAM port between the SRAM-using effects in the audio chain. Requester 0 is the delay line; requester 1 is the looper.
- Each frame starts on the per-sample strobe. Requesters are served once each, in fixed index order, with a bus-turnaround gap between slots.
- Drives the SRAM address, write enable and DQ output-enable. Reports timeout and overrun faults.

Parameters:
NUM_REQ, 2, number of requesters (>=2); slot order is index 0..NUM_REQ-1
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width
TIMEOUT, 32, max cycles a slot may hold the port (>=2)

Ports:
i_clk  in  1  audio bit clock; all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_frame_start  in  1  one-cycle strobe: start of a new sample frame
i_req  in  NUM_REQ  requester wants its slot this frame (sampled in ARB)
i_done  in  NUM_REQ  requester finished its access (honoured only while granted)
i_addr  in  NUM_REQ*ADDR_W  flattened per-requester address, requester k at [k*ADDR_W +: ADDR_W]
i_we_n  in  NUM_REQ  per-requester active-low write enable
i_wdata  in  NUM_REQ*DATA_W  flattened per-requester write data
i_dq_in  in  DATA_W  SRAM DQ read value
i_clr_flags  in  1  clears sticky flags
o_grant  out  NUM_REQ  one-hot registered grant
o_rdata  out  DATA_W  i_dq_in passed through combinationally
o_sram_addr  out  ADDR_W  SRAM address
o_sram_we_n  out  1  SRAM write enable, active low
o_dq_oe  out  1  1 = drive o_dq_out onto DQ
o_dq_out  out  DATA_W  write data to DQ
o_busy  out  1  frame in progress (state != IDLE)
o_timeout  out  1  sticky: a slot was force-ended by TIMEOUT
o_overrun  out  1  sticky: i_frame_start arrived while busy

Behaviour:
- Reset values: o_grant=0, o_sram_addr=0, o_sram_we_n=1, o_dq_oe=0, o_dq_out=0, o_busy=0, o_timeout=0, o_overrun=0, slot index=0, cycle counter=0, state=IDLE.
- FSM states: IDLE, ARB, GRANT, GAP.
  - IDLE: on i_frame_start, set idx=0 and go to ARB.
  - ARB: if i_req[idx], go to GRANT and clear the counter. Otherwise idx+1, or go to IDLE if idx==NUM_REQ-1. ARB spends one cycle per index.
  - GRANT:
    - o_grant[idx]=1.
    - o_sram_addr=i_addr[idx] and o_sram_we_n=i_we_n[idx].
    - o_dq_oe=~i_we_n[idx] and o_dq_out=i_wdata[idx].
    - These outputs are combinational from the requester's inputs, qualified by the registered grant.
    - The counter increments each cycle. Go to GAP on i_done[idx] or when counter==TIMEOUT-1. The timeout exit sets o_timeout.
  - GAP: exactly one cycle. o_grant=0, we_n=1, oe=0, address held at its last value. Then idx+1 → ARB, or IDLE if idx==NUM_REQ-1.
- Latency: i_frame_start sampled at edge t → ARB at t+1 → grant visible from t+2 for a requesting idx 0. Each skipped requester adds 1 cycle.
- Outside GRANT: o_sram_we_n=1 and o_dq_oe=0. o_dq_oe and a low o_sram_we_n are never asserted at the same time as a grant change.
- i_done for a non-granted index is ignored. i_done together with the timeout limit counts as done: no timeout flag.
- i_frame_start while o_busy=1: sets o_overrun; the current frame continues; no restart.
- i_clr_flags clears both sticky flags. If a flag-setting event occurs in the same cycle, the set wins.
- i_rst asserted mid-grant: all outputs go to their reset values asynchronously; the write is dropped.

Optional Feature:
- Macro: SRAM_ARB_ADDR_SETUP_EN.
- Defined: adds state SETUP between ARB and GRANT. For 1 cycle o_sram_addr=i_addr[idx], we_n=1, oe=0, o_grant=0. The grant then asserts, so grant latency is t+3. The timeout counter starts in GRANT.
- Undefined: ARB goes directly to GRANT.

Decomposition:
- Package sram_arb_pkg: state enum (IDLE, ARB, SETUP, GRANT, GAP), a clog2-based index width function, default TIMEOUT constant, requester index constants REQ_DELAY=0 and REQ_LOOP=1.
- No sub-module. A single FSM with a generate-based port mux is sufficient.

Test Plan:
- Both requesting: strobe at t; req=2'b11; i_done[0] at t+4, i_done[1] at t+8 → grant 01 during t+2..t+4, GAP at t+5, grant 10 during t+7..t+8, IDLE at t+10.
- Skip: req=2'b10 → idx0 ARB cycle skipped, grant 10 from t+3. With req=0 → IDLE at t+3 and no grant ever.
- Write drive: granted req0 with we_n=0, addr=20'h00123, wdata=16'hBEEF → o_sram_addr=20'h00123, o_dq_oe=1, o_dq_out=16'hBEEF. In GAP: oe=0, we_n=1.
- Timeout: TIMEOUT=32, req0 never raises done → grant held for exactly 32 cycles, o_timeout=1. i_clr_flags then clears it.
- Overrun/reset: strobe during GRANT → o_overrun=1 and the frame completes normally. Raising i_rst mid-write → we_n=1, oe=0, grant=0 immediately.
- With SRAM_ARB_ADDR_SETUP_EN: same stimulus as the first case → address valid at t+2 with we_n=1, grant from t+3.
